mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_W, default 32, data path width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter REG_ADDR_W, default 5, register file address width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 valid_i  in  1  EX/MEM slot holds a live instruction.
REQ-007 wd_i / wreg_i / wdata_i  in  REG_ADDR_W / 1 / DATA_W  destination, write enable, ALU result.
REQ-008 mem_op_i  in  4  NONE, LB, LBU, LH, LHU, LW, SB, SH, SW; encodings are defined in the package.
REQ-009 mem_addr_i / mem_sdata_i  in  ADDR_W / DATA_W  effective address and store data.
REQ-010 wd_o / wreg_o / wdata_o  out  REG_ADDR_W / 1 / DATA_W  result to MEM/WB.
REQ-011 stall_o  out  1  freeze IF..EX/MEM while asserted.
REQ-012 exc_align_o  out  1  misaligned access, one-cycle pulse.
REQ-013 dmem_req_o / dmem_we_o  out  1 / 1  bus request and write strobe.
REQ-014 dmem_addr_o / dmem_be_o / dmem_wdata_o  out  ADDR_W / DATA_W/8 / DATA_W  lane-aligned address, byte enables, store data.
REQ-015 dmem_gnt_i / dmem_rvalid_i / dmem_rdata_i  in  1 / 1 / DATA_W  grant, response valid, read data.

Function
REQ-016 Non-memory ops and valid_i=0 SHALL pass wd/wreg/wdata through combinationally with zero latency and stall_o=0; with valid_i=0, wreg_o SHALL be 0.
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT.
REQ-018 In IDLE with a valid memory op, dmem_req_o SHALL be asserted in the same cycle. dmem_gnt_i=1 SHALL move the FSM to WAIT; otherwise it SHALL move to REQ.
REQ-019 In REQ, dmem_req_o and all bus outputs SHALL be held stable until dmem_gnt_i=1, then the FSM SHALL move to WAIT.
REQ-020 In WAIT, dmem_rvalid_i=1 SHALL return the FSM to IDLE; this cycle is the completion cycle.
REQ-021 stall_o SHALL be 1 from the first memory-op cycle through the cycle before completion, and 0 in the completion cycle. Inputs are guaranteed stable while stall_o=1.
REQ-022 On load completion, wdata_o SHALL be the addressed byte or half selected from dmem_rdata_i, sign-extended (LB, LH) or zero-extended (LBU, LHU), and wreg_o SHALL be wreg_i.
REQ-023 For stores, wreg_o SHALL be 0, and the store SHALL complete on dmem_rvalid_i, which is the write acknowledge.
REQ-024 dmem_addr_o SHALL be mem_addr_i with the low log2(DATA_W/8) bits cleared. dmem_be_o SHALL select 1, 2 or 4 lanes from the op and the low address bits.
REQ-025 dmem_wdata_o SHALL replicate the store byte or half across all lanes.
REQ-026 When dmem_gnt_i and dmem_rvalid_i arrive in the same cycle in REQ, the FSM SHALL treat the grant only; responses never precede grants.
REQ-027 Back-to-back memory ops SHALL be handled as follows: the new op is sampled in the IDLE cycle after completion, which gives a minimum of 2 cycles per access.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and stall_o, dmem_req_o, dmem_we_o and exc_align_o SHALL be 0.
REQ-029 While rst=1, wd_o SHALL be 0, wreg_o SHALL be 0 and wdata_o SHALL be 0.
REQ-030 Reset asserted in REQ or WAIT SHALL abandon the transaction, and any late dmem_rvalid_i SHALL be ignored until the next request.

Configuration
REQ-031 With MEM_LSU_ALIGN_CHK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL behave as follows: issue no bus request, pulse exc_align_o for one cycle, force wreg_o=0, and leave stall_o at 0.
REQ-032 Without MEM_LSU_ALIGN_CHK_EN, exc_align_o SHALL be tied to 0 and misaligned addresses SHALL be rounded down to the natural alignment of the access.

Structure
REQ-033 The mem_op encodings, the FSM state type and the ZeroWord / NOPRegAddr constants SHALL be placed in the shared package.
REQ-034 Lane select and extension SHALL be placed in one combinational sub-module, mem_lsu_align, which the load path and the store path both use.

Verification
REQ-035 Bench scenario (pass-through): ALU op with wd_i=5, wreg_i=1, wdata_i=0x1234 -> same values appear on the outputs in the same cycle, stall_o=0.
REQ-036 Bench scenario (LB with delayed grant): LB at 0x103, gnt after 2 cycles, rdata=0x80FF_FF00 -> be=4'b1000 and wdata_o=0xFFFF_FF80; stall_o high for 3 cycles, then low in the completion cycle.
REQ-037 Bench scenario (SH): SH at 0x202 with sdata=0xABCD_1234 -> dmem_wdata_o=0x1234_1234, be=4'b1100, we=1, wreg_o=0.
REQ-038 Bench scenario (LHU with zero-wait): LHU at 0x0, gnt in the same cycle, rvalid next cycle, rdata=0x0000_9ABC -> wdata_o=0x0000_9ABC.
REQ-039 Bench scenario (reset mid-operation): rst asserted in WAIT -> FSM goes to IDLE, stall_o=0, and a late rvalid produces no output.
REQ-040 Bench scenario (MEM_LSU_ALIGN_CHK_EN defined): LW at 0x101 -> exc_align_o pulses once, dmem_req_o stays 0, wreg_o=0.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit: memory op encodings,
// FSM state type, access-size helpers and the pipeline zero constants.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } access_size_e;

  localparam logic [63:0] ZeroWord   = 64'h0;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  function automatic access_size_e op_size(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
      MEM_LW, MEM_SW:          return SZ_WORD;
      default:                 return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    case (op_size(op))
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane steering for the LSU: byte enables and replicated store data on the
// way out, lane select plus sign/zero extension of read data on the way in.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  mem_op_e             op_i,
  input  logic [OFF_W-1:0]    off_i,
  input  logic [DATA_W-1:0]   sdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] be_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   ldata_o
);

  localparam int NB = DATA_W / 8;

  logic [OFF_W-1:0]  off_a;
  logic [DATA_W-1:0] shifted;

  // Misaligned offsets are rounded down to the access size here, so the
  // bus never sees a lane pattern that straddles the natural boundary.
  always_comb begin
    off_a   = off_i;
    be_o    = '0;
    wdata_o = '0;
    case (op_size(op_i))
      SZ_BYTE: begin
        off_a   = off_i;
        be_o    = NB'(1) << off_a;
        wdata_o = {NB{sdata_i[7:0]}};
      end
      SZ_HALF: begin
        off_a   = off_i & ~OFF_W'(1);
        be_o    = NB'(2'b11) << off_a;
        wdata_o = {(NB / 2){sdata_i[15:0]}};
      end
      SZ_WORD: begin
        off_a   = off_i & ~OFF_W'(3);
        be_o    = NB'(4'hF) << off_a;
        wdata_o = {(NB / 4){sdata_i[31:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rdata_i >> {off_a, 3'b000};
    ldata_o = '0;
    case (op_i)
      MEM_LB:  ldata_o = DATA_W'($signed(shifted[7:0]));
      MEM_LBU: ldata_o = DATA_W'(shifted[7:0]);
      MEM_LH:  ldata_o = DATA_W'($signed(shifted[15:0]));
      MEM_LHU: ldata_o = DATA_W'(shifted[15:0]);
      MEM_LW:  ldata_o = DATA_W'($signed(shifted[31:0]));
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus and stalls the
// pipeline for the access. MEM_LSU_ALIGN_CHK_EN enables misalignment traps.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_sdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stall_o,
  output logic                  exc_align_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [DATA_W/8-1:0]   dmem_be_o,
  output logic [DATA_W-1:0]     dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_W-1:0]     dmem_rdata_i,
  output lsu_state_e            state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  mem_op_e           op;
  logic              is_mem;
  logic              misaligned;
  logic              go;
  logic              req_c;
  logic              stall_c;
  logic              done_c;
  logic [DATA_W-1:0] ldata;
  lsu_state_e        state_q, state_d;

  assign op     = mem_op_e'(mem_op_i);
  assign is_mem = valid_i && (op_size(op) != SZ_NONE);

`ifdef MEM_LSU_ALIGN_CHK_EN
  assign misaligned = is_mem && is_misaligned(op, mem_addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign go = is_mem && !misaligned;

  // Bus handshake: dmem_req_o and its payload hold until dmem_gnt_i is seen
  // high; one dmem_rvalid_i (read data or write ack) is then accepted in
  // WAIT only, so an rvalid coinciding with the grant is never consumed.
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (go) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          state_d = dmem_gnt_i ? LSU_WAIT : LSU_REQ;
        end
      end
      LSU_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem_gnt_i) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (dmem_rvalid_i) begin
          done_c  = 1'b1;
          state_d = LSU_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  mem_lsu_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .op_i    (op),
    .off_i   (mem_addr_i[OFF_W-1:0]),
    .sdata_i (mem_sdata_i),
    .rdata_i (dmem_rdata_i),
    .be_o    (dmem_be_o),
    .wdata_o (dmem_wdata_o),
    .ldata_o (ldata)
  );

  assign dmem_addr_o = {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_req_o  = req_c & ~rst;
  assign dmem_we_o   = req_c & is_store(op) & ~rst;
  assign stall_o     = stall_c & ~rst;
  assign exc_align_o = misaligned & ~rst;
  assign state_o     = state_q;

  // Memory ops only write back in their completion cycle, and only loads.
  always_comb begin
    wd_o    = wd_i;
    wreg_o  = 1'b0;
    wdata_o = wdata_i;
    if (rst) begin
      wd_o    = REG_ADDR_W'(NOPRegAddr);
      wdata_o = ZeroWord[DATA_W-1:0];
    end else if (valid_i) begin
      if (!is_mem) begin
        wreg_o = wreg_i;
      end else if (done_c && is_load(op)) begin
        wreg_o  = wreg_i;
        wdata_o = ldata;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu with directed corner cases
// (delayed grant, zero-wait, reset mid-access, misalignment).
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int RES_W = 47;
  localparam int BUS_W = 69;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_o;
  logic        exc_align_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  lsu_state_e  state_o;

  logic [RES_W-1:0] exp_q[$];
  logic [BUS_W-1:0] bus_q[$];
  int total;
  int bad;
  int stall_cnt;
  bit mon_en;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .wd_i          (wd_i),
    .wreg_i        (wreg_i),
    .wdata_i       (wdata_i),
    .mem_op_i      (mem_op_i),
    .mem_addr_i    (mem_addr_i),
    .mem_sdata_i   (mem_sdata_i),
    .wd_o          (wd_o),
    .wreg_o        (wreg_o),
    .wdata_o       (wdata_o),
    .stall_o       (stall_o),
    .exc_align_o   (exc_align_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .state_o       (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: compares every bus request cycle and every retired instruction
  always @(negedge clk) begin
    logic [BUS_W-1:0] be_exp;
    if (rst) begin
      stall_cnt = 0;
    end else if (mon_en) begin
      if (dmem_req_o) begin
        if (bus_q.size() == 0) begin
          chk("req_no_op", dmem_req_o, 1'b0);
        end else begin
          be_exp = bus_q[0];
          chk("bus", {dmem_we_o, dmem_addr_o, dmem_be_o, be_exp[68] ? dmem_wdata_o : 32'h0}, be_exp);
          if (dmem_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (valid_i) begin
        if (stall_o) begin
          stall_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result: got wd=%0d wreg=%0d data=%h want no output", wd_o, wreg_o, wdata_o);
          end else begin
            chk("result", {stall_cnt[7:0], exc_align_o, wreg_o, wd_o, wdata_o}, exp_q.pop_front());
          end
          stall_cnt = 0;
        end
      end else begin
        chk("idle", {wreg_o, exc_align_o, stall_o, dmem_req_o}, 4'b0);
      end
    end
  end

  // driver + reference model: g = grant cycle index, r = cycles from grant to rvalid,
  // dup = also raise rvalid in the grant cycle (only meaningful when g > 0)
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                       input int g, input int r, input logic [31:0] rd, input bit dup);
    int sz;
    int off;
    bit ld, st, mis, go;
    logic [31:0] v, res, rep;
    logic [63:0] mask;
    logic [3:0] be;
    logic [7:0] stl;
    sz = 0; ld = 0; st = 0;
    case (op)
      4'd1, 4'd2: begin sz = 1; ld = 1; end
      4'd3, 4'd4: begin sz = 2; ld = 1; end
      4'd5:       begin sz = 4; ld = 1; end
      4'd6:       begin sz = 1; st = 1; end
      4'd7:       begin sz = 2; st = 1; end
      4'd8:       begin sz = 4; st = 1; end
      default:    sz = 0;
    endcase
    mis = 0;
`ifdef MEM_LSU_ALIGN_CHK_EN
    mis = (sz > 0) && ((a % sz) != 0);
`endif
    go  = (sz > 0) && !mis;
    off = (sz > 0) ? (int'(a % 4) / sz) * sz : 0;
    be  = 4'(((1 << sz) - 1) << off);
    v   = rd >> (8 * off);
    case (op)
      4'd1:    res = 32'($signed(v[7:0]));
      4'd2:    res = {24'h0, v[7:0]};
      4'd3:    res = 32'($signed(v[15:0]));
      4'd4:    res = {16'h0, v[15:0]};
      4'd5:    res = rd;
      default: res = wdat;
    endcase
    if (!(go && ld)) res = wdat;
    rep = 32'h0;
    if (sz > 0) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      for (int i = 0; i < 4 / sz; i++) rep |= 32'(({32'h0, sd} & mask) << (8 * sz * i));
    end
    stl = go ? 8'(g + r) : 8'd0;
    exp_q.push_back({stl, mis, (sz == 0) ? wr : (go && ld && wr), wd, res});
    if (go) bus_q.push_back({st, a & 32'hFFFF_FFFC, be, st ? rep : 32'h0});

    valid_i = 1'b1; mem_op_i = op; mem_addr_i = a; mem_sdata_i = sd;
    wd_i = wd; wreg_i = wr; wdata_i = wdat; dmem_rdata_i = rd;
    if (go) begin
      for (int c = 0; c <= g + r; c++) begin
        dmem_gnt_i    = (c == g);
        dmem_rvalid_i = (c == g + r) || (dup && g > 0 && c == g);
        @(posedge clk); #1;
      end
    end else begin
      @(posedge clk); #1;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; mem_op_i = 4'd0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_mid_op();
    bus_q.push_back({1'b0, 32'h0000_0300, 4'hF, 32'h0});
    valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h300; wd_i = 5'd9;
    wreg_i = 1'b1; wdata_i = 32'h77; dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0; rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", {stall_o, dmem_req_o, dmem_we_o, exc_align_o}, 4'b0);
    chk("rst_mid_out", {wd_o, wreg_o, wdata_o}, 38'h0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_mid_idle", state_o, LSU_IDLE);
    chk("late_rvalid_out", {wreg_o, stall_o}, 2'b0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("after_late_rvalid", state_o, LSU_IDLE);
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0; stall_cnt = 0; mon_en = 0;
    rst = 1'b1; valid_i = 1'b1; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    mem_op_i = 4'd0; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", state_o, LSU_IDLE);
    chk("reset_ctrl", {stall_o, dmem_req_o, dmem_we_o, exc_align_o}, 4'b0);
    chk("reset_out", {wd_o, wreg_o, wdata_o}, 38'h0);
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0; mon_en = 1;

    do_op(4'd0, 32'h0,   32'h0,         5'd5, 1'b1, 32'h1234, 0, 0, 32'h0, 0);
    do_op(4'd1, 32'h103, 32'h0,         5'd3, 1'b1, 32'h0,    2, 1, 32'h80FF_FF00, 0);
    do_op(4'd7, 32'h202, 32'hABCD_1234, 5'd4, 1'b1, 32'h55,   1, 2, 32'h0, 0);
    do_op(4'd4, 32'h0,   32'h0,         5'd6, 1'b1, 32'h0,    0, 1, 32'h0000_9ABC, 0);
    idle(1);
    do_op(4'd5, 32'h101, 32'h0,         5'd8, 1'b1, 32'h99,   0, 1, 32'h1122_3344, 0);
    do_op(4'd3, 32'h102, 32'h0,         5'd2, 1'b1, 32'h0,    1, 1, 32'h8001_0000, 1);
    do_op(4'd8, 32'h404, 32'h0BAD_CAFE, 5'd1, 1'b1, 32'h0,    3, 2, 32'h0, 1);
    reset_mid_op();

    for (int n = 0; n < 80; n++) begin
      int g;
      g = $urandom_range(0, 3);
      do_op(4'($urandom_range(0, 8)), 32'($urandom_range(0, 4095)), $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
            g, $urandom_range(1, 3), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    chk("queues_drained", 32'(exp_q.size() + bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
